// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle CPU controller.
// master = controller side, slave = datapath/IR side.
interface multicycle_control_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic                reg_write;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic [ALU_OP_W-1:0] alu_op;
  logic                halted;
  logic                retire;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output ir_write, pc_write, pc_src, reg_write, alu_src, mem_read,
           mem_write, mem_to_reg, alu_op, halted, retire
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  ir_write, pc_write, pc_src, reg_write, alu_src, mem_read,
           mem_write, mem_to_reg, alu_op, halted, retire
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 16-bit CPU.
// Define CTRL_MEM_READY_EN to end MEM on mem_ready; otherwise MEM lasts MEM_LAT cycles.
module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  // ISA opcode encoding; 13 and 14 are unassigned and execute as NOP
  localparam logic [OPCODE_W-1:0] OPCODE_ADD   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OPCODE_SUB   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OPCODE_AND   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OPCODE_OR    = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OPCODE_XOR   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OPCODE_ADDI  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OPCODE_ANDI  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OPCODE_ORI   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OPCODE_XORI  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OPCODE_STORE = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OPCODE_BEQ   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OPCODE_BNE   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OPCODE_HALT  = OPCODE_W'(15);

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [OPCODE_W-1:0] op_q;
  logic                mem_done;
  logic                is_branch;
  logic                is_mem_op;
  logic                branch_taken;

  function automatic logic is_defined(input logic [OPCODE_W-1:0] op);
    return (op <= OPCODE_BNE) || (op == OPCODE_HALT);
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_SUB, OPCODE_BEQ, OPCODE_BNE: return ALU_SUB;
      OPCODE_AND, OPCODE_ANDI:            return ALU_AND;
      OPCODE_OR,  OPCODE_ORI:             return ALU_OR;
      OPCODE_XOR, OPCODE_XORI:            return ALU_XOR;
      default:                            return ALU_ADD;
    endcase
  endfunction

  function automatic logic alu_src_of(input logic [OPCODE_W-1:0] op);
    return (op >= OPCODE_ADDI) && (op <= OPCODE_STORE);
  endfunction

  assign is_branch    = (op_q == OPCODE_BEQ) || (op_q == OPCODE_BNE);
  assign is_mem_op    = (op_q == OPCODE_LOAD) || (op_q == OPCODE_STORE);
  assign branch_taken = ((op_q == OPCODE_BEQ) &&  bus.alu_zero) ||
                        ((op_q == OPCODE_BNE) && !bus.alu_zero);

`ifdef CTRL_MEM_READY_EN
  assign mem_done = bus.mem_ready;
`else
  localparam int CNT_W = (MEM_LAT < 4) ? 2 : $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             unused_mem_ready;

  assign unused_mem_ready = bus.mem_ready;
  assign mem_done         = (wait_cnt == CNT_W'(MEM_LAT - 1));

  // Counts elapsed MEM cycles; idle at zero outside MEM
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == S_MEM && !mem_done)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end
`endif

  // State register; the opcode is captured as DECODE hands over to EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        op_q <= bus.opcode;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OPCODE_HALT)
          next_state = S_HALT;
        else if (is_defined(bus.opcode))
          next_state = S_EXEC;
        else
          next_state = S_FETCH;
      end
      S_EXEC: begin
        if (is_branch)
          next_state = S_FETCH;
        else if (is_mem_op)
          next_state = S_MEM;
        else
          next_state = S_WB;
      end
      S_MEM: begin
        if (mem_done)
          next_state = (op_q == OPCODE_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // Strobes follow the state; a reset cycle forces every output to its idle value
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.halted     = 1'b0;
    bus.retire     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
        end
        S_DECODE: bus.retire = !is_defined(bus.opcode);
        S_EXEC: begin
          bus.alu_op  = alu_op_of(op_q);
          bus.alu_src = alu_src_of(op_q);
          if (is_branch) begin
            bus.pc_write = branch_taken;
            bus.pc_src   = branch_taken;
            bus.retire   = 1'b1;
          end
        end
        S_MEM: begin
          bus.alu_op    = alu_op_of(op_q);
          bus.alu_src   = alu_src_of(op_q);
          bus.mem_read  = (op_q == OPCODE_LOAD);
          bus.mem_write = (op_q == OPCODE_STORE);
          bus.retire    = (op_q == OPCODE_STORE) && mem_done;
        end
        S_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = (op_q == OPCODE_LOAD);
          bus.retire     = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
